// File: rtl/req_apb_arb.sv
// Two-master round-robin arbiter in front of the single APB-style register request port.
// Every transfer is fully registered. A slave that never answers is cut off by a timeout.
module req_apb_arb #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk_200m,
  input  logic        rstn_200m,
  input  logic [20:0] m0_paddr,
  input  logic [20:0] m1_paddr,
  input  logic        m0_pwrite,
  input  logic        m1_pwrite,
  input  logic        m0_psel,
  input  logic        m1_psel,
  input  logic        m0_penable,
  input  logic        m1_penable,
  input  logic [15:0] m0_pwdata,
  input  logic [15:0] m1_pwdata,
  output logic        m0_pready,
  output logic        m1_pready,
  output logic [15:0] m0_prdata,
  output logic [15:0] m1_prdata,
  output logic        m0_pslverr,
  output logic        m1_pslverr,
  output logic [20:0] s_paddr,
  output logic        s_pwrite,
  output logic        s_psel,
  output logic        s_penable,
  output logic [15:0] s_pwdata,
  input  logic        s_pready,
  input  logic [15:0] s_prdata,
  output logic        timeout_pulse,
  output logic [7:0]  timeout_cnt
);

  localparam int DATA_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              gnt_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              gnt_psel;
  logic              gnt_pen;
  logic              resp_done;
  logic [DATA_W-1:0] resp_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    gnt_nxt = 1'b0;
    if (m0_psel && m1_psel)
      gnt_nxt = ~last_grant;
    else if (m1_psel)
      gnt_nxt = 1'b1;
  end

  always_comb begin
    gnt_psel  = grant ? m1_psel    : m0_psel;
    gnt_pen   = grant ? m1_penable : m0_penable;
    resp_done = s_pready || (wait_cnt == CNT_LAST);
    resp_data = TIMEOUT_DATA;
    if (s_pready)
      resp_data = s_pwrite ? '0 : s_prdata;
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn_200m) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      wait_cnt      <= '0;
      s_paddr       <= '0;
      s_pwrite      <= 1'b0;
      s_psel        <= 1'b0;
      s_penable     <= 1'b0;
      s_pwdata      <= '0;
      m0_pready     <= 1'b0;
      m1_pready     <= 1'b0;
      m0_prdata     <= '0;
      m1_prdata     <= '0;
      m0_pslverr    <= 1'b0;
      m1_pslverr    <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      m0_pready     <= 1'b0;
      m1_pready     <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        // Grant and latch the winning master's request
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant      <= gnt_nxt;
            last_grant <= gnt_nxt;
            s_paddr    <= gnt_nxt ? m1_paddr  : m0_paddr;
            s_pwrite   <= gnt_nxt ? m1_pwrite : m0_pwrite;
            s_pwdata   <= gnt_nxt ? m1_pwdata : m0_pwdata;
            s_psel     <= 1'b1;
            s_penable  <= 1'b0;
            wait_cnt   <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          s_penable <= 1'b1;
          state     <= ACCESS;
        end
        // Wait for the slave; a ready on the last allowed cycle beats the timeout
        ACCESS: begin
          if (resp_done) begin
            s_psel    <= 1'b0;
            s_penable <= 1'b0;
            state     <= RESP;
            if (!s_pready) begin
              timeout_pulse <= 1'b1;
              timeout_cnt   <= sat_inc(timeout_cnt);
            end
            // A master that walked away loses its response
            if (gnt_psel && gnt_pen) begin
              if (grant) begin
                m1_pready  <= 1'b1;
                m1_prdata  <= resp_data;
                m1_pslverr <= ~s_pready;
              end else begin
                m0_pready  <= 1'b1;
                m0_prdata  <= resp_data;
                m0_pslverr <= ~s_pready;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_apb_arb.sv
// Bench for req_apb_arb: directed literal cases, then randomized masters and slave
// checked every cycle against a transfer-timeline model.
module tb_req_apb_arb;

  localparam int T = 4;

  logic        clk_200m = 1'b0;
  logic        rstn_200m = 1'b0;
  logic [20:0] m_addr [2];
  logic        m_wr   [2];
  logic        m_sel  [2];
  logic        m_en   [2];
  logic [15:0] m_wd   [2];
  logic        s_pready = 1'b0;
  logic [15:0] s_prdata = '0;

  logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [15:0] m0_prdata, m1_prdata, s_pwdata;
  logic [20:0] s_paddr;
  logic        s_pwrite, s_psel, s_penable, timeout_pulse;
  logic [7:0]  timeout_cnt;

  req_apb_arb #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
    .clk_200m(clk_200m), .rstn_200m(rstn_200m),
    .m0_paddr(m_addr[0]), .m1_paddr(m_addr[1]),
    .m0_pwrite(m_wr[0]), .m1_pwrite(m_wr[1]),
    .m0_psel(m_sel[0]), .m1_psel(m_sel[1]),
    .m0_penable(m_en[0]), .m1_penable(m_en[1]),
    .m0_pwdata(m_wd[0]), .m1_pwdata(m_wd[1]),
    .m0_pready(m0_pready), .m1_pready(m1_pready),
    .m0_prdata(m0_prdata), .m1_prdata(m1_prdata),
    .m0_pslverr(m0_pslverr), .m1_pslverr(m1_pslverr),
    .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_psel(s_psel),
    .s_penable(s_penable), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata),
    .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt)
  );

  always #5 clk_200m = ~clk_200m;

  // Model: one in-flight transfer described by its grant edge; outputs follow from its age.
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          busy = 0;
  int          g_edge = 0;
  int          free_at = 0;
  bit          gnt = 0;
  bit          lg = 1;
  bit          act [2];
  logic        ex_psel, ex_pen, ex_wr, ex_tp;
  logic [20:0] ex_addr;
  logic [15:0] ex_wd;
  logic [1:0]  ex_mp, ex_err;
  logic [15:0] ex_rd [2];
  int          ex_tcnt;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      if (n_bad <= 25)
        $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic model_edge();
    int age;
    bit to;
    ex_mp = '0;
    ex_tp = 1'b0;
    if (!rstn_200m) begin
      busy = 0; lg = 1; free_at = cyc;
      ex_psel = 0; ex_pen = 0; ex_addr = '0; ex_wr = 0; ex_wd = '0;
      ex_rd[0] = '0; ex_rd[1] = '0; ex_err = '0; ex_tcnt = 0;
    end else if (!busy) begin
      if (cyc >= free_at && (m_sel[0] || m_sel[1])) begin
        gnt = (m_sel[0] && m_sel[1]) ? !lg : m_sel[1];
        lg = gnt; busy = 1; g_edge = cyc;
        ex_addr = m_addr[gnt]; ex_wr = m_wr[gnt]; ex_wd = m_wd[gnt];
        ex_psel = 1; ex_pen = 0;
      end
    end else begin
      age = cyc - g_edge;
      if (age == 1) begin
        ex_pen = 1;
      end else if (s_pready || age == T + 1) begin
        to = !s_pready;
        ex_psel = 0; ex_pen = 0; busy = 0; free_at = cyc + 2;
        if (to) begin
          ex_tp = 1;
          if (ex_tcnt < 255) ex_tcnt++;
        end
        if (m_sel[gnt] && m_en[gnt]) begin
          ex_mp[gnt] = 1'b1;
          ex_rd[gnt] = to ? 16'hDEAD : (ex_wr ? 16'h0000 : s_prdata);
          ex_err[gnt] = to;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare();
    chk("s_psel", 32'(s_psel), 32'(ex_psel));
    chk("s_penable", 32'(s_penable), 32'(ex_pen));
    chk("s_paddr", 32'(s_paddr), 32'(ex_addr));
    chk("s_pwrite", 32'(s_pwrite), 32'(ex_wr));
    chk("s_pwdata", 32'(s_pwdata), 32'(ex_wd));
    chk("m0_pready", 32'(m0_pready), 32'(ex_mp[0]));
    chk("m1_pready", 32'(m1_pready), 32'(ex_mp[1]));
    chk("m0_prdata", 32'(m0_prdata), 32'(ex_rd[0]));
    chk("m1_prdata", 32'(m1_prdata), 32'(ex_rd[1]));
    chk("m0_pslverr", 32'(m0_pslverr), 32'(ex_err[0]));
    chk("m1_pslverr", 32'(m1_pslverr), 32'(ex_err[1]));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(ex_tp));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(ex_tcnt));
  endtask

  task automatic step();
    @(posedge clk_200m);
    model_edge();
    #1;
    compare();
  endtask

  task automatic req(input int m, input logic [20:0] a, input logic w, input logic [15:0] d);
    m_sel[m] = 1'b1; m_en[m] = 1'b0; m_addr[m] = a; m_wr[m] = w; m_wd[m] = d;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      m_sel[m] = 1'b0; m_en[m] = 1'b0;
    end
  endtask

  task automatic drive_rand(input bit stuck);
    rstn_200m = stuck ? 1'b1 : ($urandom_range(0, 299) != 0);
    s_pready  = stuck ? 1'b0 : ($urandom_range(0, 2) == 0);
    s_prdata  = 16'($urandom);
    for (int m = 0; m < 2; m++) begin
      if (ex_mp[m]) act[m] = 0;
      if (act[m]) begin
        if ($urandom_range(0, 39) == 0) begin
          act[m] = 0; m_sel[m] = 1'b0; m_en[m] = 1'b0;
        end else begin
          m_en[m] = 1'b1;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        act[m] = 1;
        req(m, 21'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
      end else begin
        m_sel[m] = 1'b0; m_en[m] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_wr[m] = 1'b0; m_sel[m] = 1'b0; m_en[m] = 1'b0; m_wd[m] = '0;
      act[m] = 0;
    end
    ex_rd[0] = '0; ex_rd[1] = '0;

    // Reset state
    step();
    chk("lit_rst_psel", 32'(s_psel), 32'h0);
    chk("lit_rst_m0_prdata", 32'(m0_prdata), 32'h0);
    chk("lit_rst_tcnt", 32'(timeout_cnt), 32'h0);
    rstn_200m = 1'b1;

    // Zero-wait read on m0: pready three edges after psel
    req(0, 21'h12345, 1'b0, 16'h0);
    step();
    chk("lit_setup_pen", 32'(s_penable), 32'h0);
    m_en[0] = 1'b1;
    step();
    s_pready = 1'b1; s_prdata = 16'h1234;
    step();
    chk("lit_rd_pready", 32'(m0_pready), 32'h1);
    chk("lit_rd_data", 32'(m0_prdata), 32'h1234);
    chk("lit_rd_err", 32'(m0_pslverr), 32'h0);
    chk("lit_rd_m1", 32'(m1_pready), 32'h0);
    idle_all(); s_pready = 1'b0;
    step();
    chk("lit_rd_pulse", 32'(m0_pready), 32'h0);
    chk("lit_rd_hold", 32'(m0_prdata), 32'h1234);

    // Timeout: slave never ready
    req(0, 21'h00042, 1'b0, 16'h0);
    step();
    m_en[0] = 1'b1;
    repeat (T) step();
    chk("lit_to_psel", 32'(s_psel), 32'h1);
    step();
    chk("lit_to_pready", 32'(m0_pready), 32'h1);
    chk("lit_to_data", 32'(m0_prdata), 32'hDEAD);
    chk("lit_to_err", 32'(m0_pslverr), 32'h1);
    chk("lit_to_pulse", 32'(timeout_pulse), 32'h1);
    chk("lit_to_cnt", 32'(timeout_cnt), 32'h1);
    idle_all();
    step();
    chk("lit_to_pulse_end", 32'(timeout_pulse), 32'h0);

    // Ready on the last allowed cycle wins over the timeout
    req(1, 21'h00777, 1'b0, 16'h0);
    step();
    m_en[1] = 1'b1;
    repeat (T) step();
    s_pready = 1'b1; s_prdata = 16'hBEEF;
    step();
    chk("lit_last_pready", 32'(m1_pready), 32'h1);
    chk("lit_last_data", 32'(m1_prdata), 32'hBEEF);
    chk("lit_last_err", 32'(m1_pslverr), 32'h0);
    chk("lit_last_cnt", 32'(timeout_cnt), 32'h1);
    idle_all(); s_pready = 1'b0;
    step();

    // Reset during ACCESS, then a tie goes to m0 and m1 stays pending
    req(1, 21'h00100, 1'b1, 16'h1111);
    step();
    m_en[1] = 1'b1;
    step();
    idle_all(); rstn_200m = 1'b0;
    step();
    chk("lit_mid_rst_psel", 32'(s_psel), 32'h0);
    chk("lit_mid_rst_addr", 32'(s_paddr), 32'h0);
    chk("lit_mid_rst_cnt", 32'(timeout_cnt), 32'h0);
    rstn_200m = 1'b1;
    req(0, 21'h0AAAA, 1'b1, 16'hA0A0);
    req(1, 21'h15555, 1'b0, 16'h0);
    step();
    chk("lit_tie_addr", 32'(s_paddr), 32'h0AAAA);
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    step();
    s_pready = 1'b1; s_prdata = 16'h5A5A;
    step();
    chk("lit_tie_m0", 32'(m0_pready), 32'h1);
    chk("lit_tie_wr_data", 32'(m0_prdata), 32'h0);
    m_sel[0] = 1'b0; m_en[0] = 1'b0; s_pready = 1'b0;
    step();
    step();
    chk("lit_pend_addr", 32'(s_paddr), 32'h15555);
    step();
    s_pready = 1'b1;
    step();
    chk("lit_pend_m1", 32'(m1_pready), 32'h1);
    chk("lit_pend_data", 32'(m1_prdata), 32'h5A5A);
    idle_all(); s_pready = 1'b0;
    step();

    // Random traffic, then a stuck slave long enough to saturate the counter
    for (int i = 0; i < 3000; i++) begin
      drive_rand(1'b0);
      step();
    end
    rstn_200m = 1'b0;
    step();
    for (int i = 0; i < 3000; i++) begin
      drive_rand(1'b1);
      step();
    end
    chk("lit_sat_cnt", 32'(timeout_cnt), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
